// File: rtl/sram_req_ctrl_pkg.sv
// Shared widths and response-entry payload for the SRAM request controller.
package sram_req_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 22;
  localparam int unsigned STRB_W = 4;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              write;
    logic              err;
  } rsp_entry_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO of rsp_entry_t; pointers wrap modulo DEPTH (power of two).
module sram_rsp_fifo
  import sram_req_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  rsp_entry_t               push_data,
  input  logic                     pop,
  output rsp_entry_t               head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rsp_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready front end for a byte-writable 1-cycle-read SRAM with in-order response FIFO.
// Optional address bounds check: define SRAM_REQ_CTRL_BOUNDS_CHECK_EN.
module sram_req_ctrl
  import sram_req_ctrl_pkg::*;
#(
  parameter int unsigned WORDS = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [STRB_W-1:0] req_wstrb,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic              ram_ena,
  output logic [STRB_W-1:0] ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
`ifdef SRAM_REQ_CTRL_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic             acc;
  logic             in_range;
  logic             pop;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit;
  logic             p_valid_q, p_valid_d;
  logic             p_write_q, p_write_d;
  logic             p_err_q, p_err_d;
  rsp_entry_t       push_entry;
  rsp_entry_t       head;

  // Credit counts the in-flight access so a push can never overflow the FIFO.
  always_comb begin
    in_range  = !BOUNDS_EN || (32'(req_addr) < 32'(WORDS));
    pop       = !fifo_empty && rsp_ready;
    credit    = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(p_valid_q) - (CNT_W+1)'(pop);
    req_ready = !rst && (credit < (CNT_W+1)'(DEPTH));
    acc       = req_valid && req_ready;
    ram_ena   = acc && in_range;
    ram_wen   = (ram_ena && req_we) ? req_wstrb : '0;
    ram_addr  = req_addr;
    ram_wdata = req_wdata;
    p_valid_d = acc;
    p_write_d = req_we;
    p_err_d   = acc && !in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid_q <= 1'b0;
      p_write_q <= 1'b0;
      p_err_q   <= 1'b0;
    end else begin
      p_valid_q <= p_valid_d;
      p_write_q <= p_write_d;
      p_err_q   <= p_err_d;
    end
  end

  always_comb begin
    push_entry.rdata = (p_write_q || p_err_q) ? '0 : ram_rdata;
    push_entry.write = p_write_q;
    push_entry.err   = p_err_q;
  end

  sram_rsp_fifo #(.DEPTH(DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (p_valid_q),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Head is masked while empty so idle/reset outputs read as zero.
  always_comb begin
    rsp_valid = !fifo_empty;
    rsp_rdata = fifo_empty ? '0 : head.rdata;
    rsp_write = !fifo_empty && head.write;
    rsp_err   = !fifo_empty && head.err;
  end

endmodule

// File: doc/sram_req_ctrl.md
# sram_req_ctrl

Request/response front end for the byte-writable synchronous RAM macro (32-bit words, 4 byte-enables, 1-cycle registered read). Sits directly upstream of the RAM. It accepts valid/ready requests from a bus master and drives the RAM port (`ena`/`wen`/`addr`/`wdata`). It captures `rdata` one cycle after each access and returns every request's response in order through a small response FIFO, so master backpressure never loses RAM read data.

## Interface
- `WORDS`, default 64: RAM depth in 32-bit words; must match the attached RAM.
- `DEPTH`, default 2: response FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on a cycle with `req_valid && req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_wstrb` in 4: byte enables for writes; bit i covers `wdata[8i+7:8i]`.
- `req_addr` in 22: word address.
- `req_wdata` in 32: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed on a cycle with `rsp_valid && rsp_ready`.
- `rsp_rdata` out 32: read data; 0 for writes.
- `rsp_write` out 1: echoes `req_we` of the originating request.
- `rsp_err` out 1: address out of range (see Configuration).
- `ram_ena` out 1: RAM enable.
- `ram_wen` out 4: RAM byte write enables.
- `ram_addr` out 22: RAM address.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM registered read data.

## Operation
- Accept: `acc = req_valid && req_ready`.
- RAM drive is combinational from the accept:
  - `ram_ena = acc` (and address in range when bounds check is enabled).
  - `ram_wen = (acc && req_we) ? req_wstrb : 4'b0`.
  - `ram_addr = req_addr`, `ram_wdata = req_wdata`.
- A write with `req_wstrb == 0` is a legal no-op write and still produces a response.
- Stage register `p_*` (`p_valid`, `p_write`, `p_err`) loads on every edge: `p_valid <= acc`.
- On an edge with `p_valid == 1`, push an entry into the FIFO:
  - rdata = `p_write || p_err ? 0 : ram_rdata`
  - write = `p_write`
  - err = `p_err`
- Response outputs come from the FIFO head; `rsp_valid = !empty`.
- Credit rule: `req_ready = !rst && (count + p_valid - pop) < DEPTH`, where `pop = rsp_valid && rsp_ready`.
  - This is a combinational path from `rsp_ready` to `req_ready`; it is intended.
- Simultaneous push and pop on a full FIFO is legal. The credit rule guarantees a push never overflows.
- Pointers wrap modulo `DEPTH`. `count` is `$clog2(DEPTH)+1` bits.
- Responses are strictly in request order. Reads and writes are never reordered.

## Timing
- Request accepted at edge N.
  - RAM samples at edge N; `ram_rdata` is valid after edge N.
  - The entry is pushed at edge N+1.
  - `rsp_valid` is high from edge N+1 when the FIFO was empty (2-cycle request→response latency).
- With `rsp_ready` held high, throughput is one request per cycle for `DEPTH ≥ 2`.
- Read-after-write to the same address on consecutive cycles returns the new data. The RAM performs the write at edge N; the read at edge N+1 sees it.
- Reset values:
  - `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_write=0`, `rsp_err=0`.
  - `ram_ena=0`, `ram_wen=0`.
  - `p_valid=0`; FIFO empty, pointers 0.
- Reset mid-operation: in-flight and queued responses are discarded. No RAM access is issued during reset. RAM contents are not touched.
- First accept is possible on the first cycle with `rst` low.

## Configuration
- `SRAM_REQ_CTRL_BOUNDS_CHECK_EN` defined:
  - A request with `req_addr >= WORDS` is accepted but `ram_ena` stays 0 and `ram_wen` stays 0.
  - Its response has `rsp_err=1` and `rsp_rdata=0`, with the same latency.
- Not defined:
  - `rsp_err` is tied 0.
  - All addresses pass to the RAM unchanged; behavior beyond `WORDS` is whatever the RAM does.

## Structure
- Shared package `sram_req_ctrl_pkg`:
  - `DATA_W=32`, `ADDR_W=22`, `STRB_W=4`.
  - Response entry typedef `rsp_entry_t {rdata, write, err}`.
- One sub-module: `sram_rsp_fifo`, a synchronous FIFO of `rsp_entry_t` with `DEPTH`, `push`/`pop`, and `count` output.
- Top level holds the accept logic, RAM drive, stage register and credit computation.

## Test plan
- Reset: hold `rst` 3 cycles with `req_valid=1` → `req_ready=0` and `ram_ena=0` throughout; all outputs 0.
- Write `addr=5`, `wstrb=4'b0101`, `wdata=32'hAABBCCDD` over initial `32'h11223344`, then read `addr=5` → `rsp_rdata=32'h11BB33DD`; write response has `rsp_write=1`, `rsp_rdata=0`.
- Back-to-back: 16 reads with `rsp_ready=1` → one response per cycle, in order, first response 2 cycles after first accept.
- Backpressure: `rsp_ready=0` with `DEPTH=2` → exactly 2 accepts, then `req_ready=0`; `rsp_ready=1` → both responses drain in order and `req_ready` reasserts in the same cycle.
- Reset asserted with 2 responses queued and 1 in flight → after reset `rsp_valid=0`; no stale responses ever appear.
- With `SRAM_REQ_CTRL_BOUNDS_CHECK_EN`: read `addr=64` (`WORDS=64`) → `ram_ena` stays 0, response `rsp_err=1`, `rsp_rdata=0`. Without the macro → `rsp_err=0` and `ram_ena=1`.
